// File: rtl/flit_router_n.sv
// flit_router_n: single-input, NPORTS-output wormhole forwarding stage.
// Flits are buffered in a DEPTH-entry FIFO. The head flit picks the output port, and that
// route stays locked until the tail flit has gone. Packets with an illegal destination are
// dropped, protocol errors set a sticky flag, and dropped flits are counted.
module flit_router_n #(
  parameter int unsigned DW     = 8,
  parameter int unsigned NPORTS = 4,
  parameter int unsigned PW     = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lvalid,
  output logic              lrdy,
  input  logic [DW-1:0]     ldata,
  output logic [NPORTS-1:0] rvalid,
  input  logic [NPORTS-1:0] rrdy,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [PW-1:0]     route,
  output logic              err,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] TyIllegal = 2'b00;
  localparam logic [1:0] TyHead    = 2'b01;
  localparam logic [1:0] TyTail    = 2'b11;

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  state_e        state_q, state_d;
  logic [PW-1:0] route_q, route_d;
  // Set while the locked packet's own head is still at the FIFO front.
  logic          first_q, first_d;
  logic          err_q;
  logic [7:0]    drop_q;

  logic          empty, full;
  logic          push, push_ok, push_bad;
  logic          pop, drop_pop, err_fsm;
  logic [DW-1:0] front;
  logic [1:0]    front_ty;
  logic [PW-1:0] front_port;
  logic [8:0]    drop_sum;

  // FIFO status, push qualification and front-entry decode
  always_comb begin
    empty      = (cnt_q == '0);
    full       = (cnt_q == CW'(DEPTH));
    push       = lvalid && !full;
    push_bad   = push && (ldata[DW-1:DW-2] == TyIllegal);
    push_ok    = push && !push_bad;
    front      = mem_q[rptr_q];
    front_ty   = front[DW-1:DW-2];
    front_port = front[DW-3:DW-2-PW];
  end

  // FIFO storage and pointers; illegal flits are accepted but never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= ldata;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
    end
  end

  // Route FSM next-state, pop control and per-port valid
  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    first_d  = first_q;
    pop      = 1'b0;
    drop_pop = 1'b0;
    err_fsm  = 1'b0;
    rvalid   = '0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          if (front_ty == TyHead) begin
            if (32'(front_port) < NPORTS) begin
              route_d = front_port;
              first_d = 1'b1;
              state_d = StFwd;
            end else begin
              pop      = 1'b1;
              drop_pop = 1'b1;
              state_d  = StDrop;
            end
          end else begin
            // Body or tail without a head.
            pop      = 1'b1;
            drop_pop = 1'b1;
            err_fsm  = 1'b1;
          end
        end
      end
      StFwd: begin
        if (!empty) begin
          if (front_ty == TyHead && !first_q) begin
            // Previous packet lost its tail; leave this head for re-decode.
            err_fsm = 1'b1;
            route_d = '0;
            state_d = StIdle;
          end else begin
            rvalid[route_q] = 1'b1;
            if (rrdy[route_q]) begin
              pop     = 1'b1;
              first_d = 1'b0;
              if (front_ty == TyTail) begin
                route_d = '0;
                state_d = StIdle;
              end
            end
          end
        end
      end
      StDrop: begin
        if (!empty) begin
          if (front_ty == TyHead) begin
            err_fsm = 1'b1;
            state_d = StIdle;
          end else begin
            pop      = 1'b1;
            drop_pop = 1'b1;
            if (front_ty == TyTail) begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, locked route and head-pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      route_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      first_q <= first_d;
    end
  end

  // Sticky error flag and saturating drop counter; up to two drops per cycle
  always_comb begin
    drop_sum = 9'(drop_q) + 9'(push_bad) + 9'(drop_pop);
  end

  // Error and drop-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (push_bad || err_fsm) begin
        err_q <= 1'b1;
      end
      drop_q <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end
  end

  // Output assignments
  always_comb begin
    lrdy     = !full;
    rdata    = front;
    busy     = (state_q == StFwd);
    route    = route_q;
    err      = err_q;
    drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_flit_router_n.sv
// Self-checking bench for flit_router_n: directed scenarios plus randomized packet traffic
// compared against a packet-level reference model.
module tb_flit_router_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lvalid = 1'b0;
  logic [7:0] ldata = '0;
  logic [3:0] rrdy = 4'hF;
  logic       lrdy;
  logic [3:0] rvalid;
  logic [7:0] rdata;
  logic       busy;
  logic [1:0] route;
  logic       err;
  logic [7:0] drop_cnt;

  // Second instance built with NPORTS=3.
  logic       lvalid3 = 1'b0;
  logic [7:0] ldata3 = '0;
  logic [2:0] rrdy3 = 3'b111;
  logic       lrdy3;
  logic [2:0] rvalid3;
  logic [7:0] rdata3;
  logic       busy3;
  logic [1:0] route3;
  logic       err3;
  logic [7:0] drop3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mh = 0;
  int rv3_seen = 0;
  bit rand_rrdy = 0;

  logic [7:0]  acc[$];
  int          acc_cyc[$];
  logic [11:0] obs[$];
  int          obs_cyc[$];
  logic [11:0] exp_q[$];
  bit          exp_err;
  int          exp_drop;

  flit_router_n #(.DW(8), .NPORTS(4), .PW(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .lvalid(lvalid), .lrdy(lrdy), .ldata(ldata),
    .rvalid(rvalid), .rrdy(rrdy), .rdata(rdata), .busy(busy), .route(route),
    .err(err), .drop_cnt(drop_cnt)
  );

  flit_router_n #(.DW(8), .NPORTS(3), .PW(2), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .lvalid(lvalid3), .lrdy(lrdy3), .ldata(ldata3),
    .rvalid(rvalid3), .rrdy(rrdy3), .rdata(rdata3), .busy(busy3), .route(route3),
    .err(err3), .drop_cnt(drop3)
  );

  initial forever #5 clk = ~clk;

  // Posedge counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: sampled on negedge, records transfers that complete at the next posedge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (lvalid && lrdy) begin
        acc.push_back(ldata);
        acc_cyc.push_back(cyc + 1);
      end
      for (int p = 0; p < 4; p++) begin
        if (rvalid[p] && rrdy[p]) begin
          obs.push_back({4'(p), rdata});
          obs_cyc.push_back(cyc + 1);
        end
      end
      if ($countones(rvalid) > 1) mh++;
      if (|rvalid3) rv3_seen++;
    end
  end

  // Random downstream backpressure when enabled
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rrdy) rrdy = 4'($urandom);
  end

  // Reference model: parse accepted flits into packets. Illegal flits vanish (dropped, error);
  // a packet runs from a head to its tail or to the next head (error if interrupted);
  // non-head flits outside a packet are dropped with error; packets to ports >= np are dropped.
  function automatic void run_model(input int np);
    logic [7:0] c[$];
    int i, j, p;
    bit closed;
    exp_q.delete();
    exp_err = 0;
    exp_drop = 0;
    foreach (acc[k]) begin
      if (acc[k][7:6] == 2'b00) begin
        exp_drop++;
        exp_err = 1;
      end else begin
        c.push_back(acc[k]);
      end
    end
    i = 0;
    while (i < c.size()) begin
      if (c[i][7:6] != 2'b01) begin
        exp_drop++;
        exp_err = 1;
        i++;
      end else begin
        p = int'(c[i][5:4]);
        closed = 0;
        j = i;
        do begin
          if (p < np) exp_q.push_back({4'(p), c[j]});
          else exp_drop++;
          if (c[j][7:6] == 2'b11) closed = 1;
          j++;
        end while (!closed && j < c.size() && c[j][7:6] != 2'b01);
        if (!closed && j < c.size()) exp_err = 1;
        i = j;
      end
    end
    if (exp_drop > 255) exp_drop = 255;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rand_rrdy = 0;
    lvalid = 0;
    lvalid3 = 0;
    rst = 1;
    wait_cycles(2);
    rst = 0;
    acc.delete();
    acc_cyc.delete();
    obs.delete();
    obs_cyc.delete();
    mh = 0;
    rv3_seen = 0;
  endtask

  // Present one flit on the main instance until it is accepted (bounded).
  task automatic send(input logic [7:0] f);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    lvalid = 1;
    ldata = f;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = lrdy;
      @(posedge clk);
      #1;
      n++;
    end
    lvalid = 0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: flit %h accepted=%0d required=1", f, ok);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    wait_cycles(1);
    n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
    n_chk++; if (lrdy !== 1'b1) begin n_fail++; $display("FAIL rst_lrdy: got %b want 1", lrdy); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (route !== 2'd0) begin n_fail++; $display("FAIL rst_route: got %0d want 0", route); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    n_chk++; if (lrdy3 !== 1'b1 || rvalid3 !== 3'b000) begin
      n_fail++; $display("FAIL rst_dut3: lrdy %b rvalid %b want 1 000", lrdy3, rvalid3);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    logic [7:0] pkt [6];
    pkt = '{8'h55, 8'h96, 8'h97, 8'h98, 8'h99, 8'hDA};
    do_reset();
    rrdy = 4'hF;
    send(pkt[0]);
    send(pkt[1]);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_chk++; if (route !== 2'd1) begin n_fail++; $display("FAIL basic_route: got %0d want 1", route); end
    n_chk++; if (rvalid !== 4'b0010) begin n_fail++; $display("FAIL basic_rvalid: got %b want 0010", rvalid); end
    for (int k = 2; k < 6; k++) send(pkt[k]);
    wait_cycles(6);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    n_chk++; if (obs.size() !== 6) begin n_fail++; $display("FAIL basic_count: got %0d want 6", obs.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < obs.size()) begin
        n_chk++;
        if (obs[k] !== {4'd1, pkt[k]}) begin
          n_fail++; $display("FAIL basic_flit%0d: got %h want %h", k, obs[k], {4'd1, pkt[k]});
        end
      end
    end
    if (obs.size() == 6 && acc_cyc.size() > 0) begin
      n_chk++; if (obs_cyc[0] - acc_cyc[0] !== 2) begin
        n_fail++; $display("FAIL basic_latency: got %0d want 2", obs_cyc[0] - acc_cyc[0]);
      end
      n_chk++; if (obs_cyc[5] - obs_cyc[0] !== 5) begin
        n_fail++; $display("FAIL basic_stream: span %0d want 5", obs_cyc[5] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rrdy = 4'hF;
    send(8'h55);
    send(8'h96);
    rrdy[1] = 1'b0;
    send(8'h97);
    send(8'h98);
    n_chk++; if (lrdy !== 1'b0) begin n_fail++; $display("FAIL bp_full_lrdy: got %b want 0", lrdy); end
    wait_cycles(1);
    n_chk++; if (lrdy !== 1'b0) begin n_fail++; $display("FAIL bp_hold_lrdy: got %b want 0", lrdy); end
    n_chk++; if (rvalid !== 4'b0010) begin n_fail++; $display("FAIL bp_rvalid: got %b want 0010", rvalid); end
    n_chk++; if (rdata !== 8'h55) begin n_fail++; $display("FAIL bp_rdata: got %h want 55", rdata); end
    rrdy = 4'hF;
    send(8'h99);
    send(8'hDA);
    wait_cycles(8);
    run_model(4);
    n_chk++; if (obs.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      n_chk++; if (obs[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL bp_flit%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    n_chk++; if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL bp_end: busy %b err %b want 0 0", busy, err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rrdy = 4'hF;
    send(8'h75); send(8'hB6); send(8'hFA);
    send(8'h45); send(8'h86); send(8'hC7);
    wait_cycles(8);
    run_model(4);
    n_chk++; if (obs.size() !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", obs.size()); end
    foreach (exp_q[k]) if (k < obs.size()) begin
      n_chk++; if (obs[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL b2b_flit%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    if (obs.size() >= 4) begin
      n_chk++; if (obs[0][11:8] !== 4'd3 || obs[3][11:8] !== 4'd0) begin
        n_fail++; $display("FAIL b2b_ports: got %0d,%0d want 3,0", obs[0][11:8], obs[3][11:8]);
      end
      n_chk++; if (obs_cyc[3] - obs_cyc[2] !== 2) begin
        n_fail++; $display("FAIL b2b_gap: got %0d want 2", obs_cyc[3] - obs_cyc[2]);
      end
    end
  endtask

  task automatic test_nports3();
    logic [7:0] pkt [3];
    bit ok;
    pkt = '{8'h75, 8'hB6, 8'hFA};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      lvalid3 = 1;
      ldata3 = pkt[k];
      @(negedge clk);
      ok = lrdy3;
      @(posedge clk);
      #1;
      n_chk++; if (!ok) begin n_fail++; $display("FAIL np3_accept%0d: lrdy %b want 1", k, ok); end
    end
    lvalid3 = 0;
    wait_cycles(4);
    n_chk++; if (drop3 !== 8'd3) begin n_fail++; $display("FAIL np3_drop: got %0d want 3", drop3); end
    n_chk++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL np3_err: got %b want 0", err3); end
    n_chk++; if (rv3_seen !== 0) begin n_fail++; $display("FAIL np3_rvalid: %0d cycles want 0", rv3_seen); end
    n_chk++; if (busy3 !== 1'b0 || lrdy3 !== 1'b1) begin
      n_fail++; $display("FAIL np3_idle: busy %b lrdy %b want 0 1", busy3, lrdy3);
    end
  endtask

  task automatic test_missing_tail();
    do_reset();
    rrdy = 4'hF;
    send(8'h55); send(8'h96);
    send(8'h75); send(8'hB6); send(8'hFA);
    wait_cycles(8);
    run_model(4);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL mt_err: got %b want 1", err); end
    n_chk++; if (obs.size() !== 5) begin n_fail++; $display("FAIL mt_count: got %0d want 5", obs.size()); end
    foreach (exp_q[k]) if (k < obs.size()) begin
      n_chk++; if (obs[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL mt_flit%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mt_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rrdy = 4'h0;
    send(8'h55);
    send(8'h96);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre_busy: got %b want 1", busy); end
    rst = 1;
    #1;
    n_chk++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL rm_rvalid: got %b want 0000", rvalid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_chk++; if (lrdy !== 1'b1) begin n_fail++; $display("FAIL rm_lrdy: got %b want 1", lrdy); end
    wait_cycles(1);
    rst = 0;
    acc.delete(); acc_cyc.delete(); obs.delete(); obs_cyc.delete();
    rrdy = 4'hF;
    send(8'h45); send(8'h86); send(8'hC7);
    wait_cycles(6);
    run_model(4);
    n_chk++; if (obs.size() !== 3) begin n_fail++; $display("FAIL rm_count: got %0d want 3", obs.size()); end
    foreach (exp_q[k]) if (k < obs.size()) begin
      n_chk++; if (obs[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rm_flit%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rm_err: got %b want 0", err); end
  endtask

  task automatic test_drop_sat();
    do_reset();
    rrdy = 4'hF;
    // Alternate illegal flits with stray bodies so two drops can land in one cycle.
    for (int k = 0; k < 254; k++) send((k % 2 == 0) ? 8'h01 : 8'h81);
    wait_cycles(3);
    n_chk++; if (drop_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", drop_cnt); end
    send(8'h02);
    wait_cycles(3);
    n_chk++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", drop_cnt); end
    for (int k = 0; k < 40; k++) send((k % 2 == 0) ? 8'hC1 : 8'h03);
    wait_cycles(3);
    n_chk++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", err); end
    n_chk++; if (obs.size() !== 0) begin n_fail++; $display("FAIL sat_out: got %0d want 0", obs.size()); end
  endtask

  task automatic test_random();
    logic [7:0] f;
    int kind, len;
    logic [1:0] port;
    do_reset();
    rand_rrdy = 1;
    for (int pk = 0; pk < 40; pk++) begin
      kind = $urandom_range(0, 9);
      f = 8'($urandom);
      if (kind == 0) begin
        f[7:6] = 2'b00;
        send(f);
      end else if (kind == 1) begin
        f[7] = 1'b1;
        send(f);
      end else begin
        port = 2'($urandom_range(0, 3));
        f[7:6] = 2'b01;
        f[5:4] = port;
        send(f);
        len = $urandom_range(0, 3);
        for (int b = 0; b < len; b++) begin
          f = 8'($urandom);
          f[7:6] = 2'b10;
          send(f);
        end
        if (kind != 2) begin
          f = 8'($urandom);
          f[7:6] = 2'b11;
          send(f);
        end
      end
    end
    rand_rrdy = 0;
    #2;
    rrdy = 4'hF;
    wait_cycles(20);
    run_model(4);
    n_chk++; if (obs.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < obs.size()) begin
      n_chk++; if (obs[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rnd_flit%0d: got %h want %h", k, obs[k], exp_q[k]);
      end
    end
    n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err: got %b want %b", err, exp_err); end
    n_chk++; if (int'(drop_cnt) !== exp_drop) begin
      n_fail++; $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, exp_drop);
    end
    n_chk++; if (mh !== 0) begin n_fail++; $display("FAIL rnd_onehot: %0d multi-hot cycles want 0", mh); end
  endtask

  initial begin
    wait_cycles(2);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_nports3();
    test_missing_tail();
    test_reset_mid();
    test_drop_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_router_n.md
Name: flit_router_n

Overview:
- Parametrised single-input, N-output wormhole forwarding stage. Successor to the fixed 4-port ibuffer/decoder/arbiter/forward chain.
- Buffers incoming flits in a DEPTH-entry FIFO and decodes the destination from the head flit. Locks the route for the whole packet until the tail flit, then releases it.
- Adds behaviour the fixed chain lacks: drop of illegal-destination packets, protocol-error detection and a drop counter.
- Sits between a link input and NPORTS downstream valid/rdy consumers.

Parameters:
- DW, 8, flit width in bits (min 4). Bits [DW-1:DW-2] are the flit type: 01 head, 10 body, 11 tail, 00 illegal.
- NPORTS, 4, number of output ports (2..16).
- PW, 2, width of the port field; the field is head bits [DW-3:DW-2-PW]. Must satisfy 2^PW >= NPORTS and PW <= DW-2.
- DEPTH, 4, FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- lvalid  in  1  input flit valid
- lrdy  out  1  input ready; transfer occurs when lvalid && lrdy at the rising edge
- ldata  in  DW  input flit
- rvalid  out  NPORTS  per-port output valid; at most one bit set
- rrdy  in  NPORTS  per-port downstream ready
- rdata  out  DW  output flit, shared by all ports; meaningful where rvalid is set
- busy  out  1  route locked (state FWD)
- route  out  PW  locked port number; 0 when idle
- err  out  1  sticky protocol-error flag
- drop_cnt  out  8  count of dropped flits, saturating at 255

Behaviour:
- Reset: FIFO empty, state IDLE, rvalid=0, lrdy=1, busy=0, route=0, err=0, drop_cnt=0, rdata=0. Reset applied mid-packet discards FIFO contents and the lock immediately.
- FIFO:
  - lrdy = !full, derived from registered occupancy.
  - Push and pop in the same cycle are allowed whenever not full; occupancy stays unchanged.
  - When full, lrdy=0; a flit presented with lvalid=1 is held by the sender, never lost.
  - Pointers wrap modulo DEPTH.
  - Illegal-type (00) flits that are accepted are not written; err is set and drop_cnt increments.
- rdata is the FIFO front entry, combinational from storage, regardless of whether any rvalid bit is set.
- States:
  - IDLE. FIFO front is examined when non-empty.
    - Head with port < NPORTS: latch route, go to FWD, no pop this cycle.
    - Head with port >= NPORTS: pop, drop_cnt++, go to DROP.
    - Body or tail: pop, drop_cnt++, err=1, stay in IDLE.
  - FWD.
    - rvalid[route] = !empty. A pop occurs when rvalid[route] && rrdy[route].
    - Popped tail: go to IDLE, busy=0 on the next cycle.
    - Head at the front while in FWD (missing tail): err=1, no pop, go to IDLE so that head is re-decoded.
  - DROP.
    - Pop every non-empty cycle; drop_cnt++ per flit.
    - Popped tail: go to IDLE.
    - Head at the front: err=1, go to IDLE without popping.
- Latency: a head accepted at edge t is decoded at edge t+1 and presented (rvalid high) in the cycle after edge t+1. Minimum 2 cycles from acceptance to head forwarding.
- Throughput: back-to-back body flits stream at 1 flit/cycle when rrdy is held high.
- Backpressure: when rrdy[route]=0, the front flit, rdata and rvalid stay stable until accepted.
- Flits are forwarded with no modification; the head flit is forwarded too.
- drop_cnt saturates at 255, does not wrap, and is cleared only by rst.
- err is cleared only by rst.

Test Plan:
- Reset, then send 55,96,97,98,99,DA (hex) with all rrdy=1.
  -> head 55 selects port 1, busy=1, route=1. rvalid=0010 for 6 cycles, first one 2 cycles after the head is accepted. busy=0 after DA. err=0.
- Same packet with rrdy[1]=0 for 3 cycles mid-body.
  -> FIFO fills to 4 and lrdy=0 while full. No flit is lost or duplicated; output order equals input order.
- Packets 75,B6,FA then 45,86,C7 back-to-back.
  -> first on port 3, second on port 0. Exactly one idle decode cycle between FA and 45 on the output.
- NPORTS=3 build, head 75 (port 3), body B6, tail FA.
  -> all 3 flits dropped, drop_cnt=3, rvalid stays 000, err=0.
- Head 55, body 96, then head 75 with no tail.
  -> 55 and 96 go to port 1, err=1, then 75 is re-decoded and its packet goes to port 3.
- Assert rst while in FWD with 2 flits buffered.
  -> immediately rvalid=0, busy=0, lrdy=1. After release, a fresh packet routes correctly.
